// File: rtl/seg_display_arbiter.sv
// Arbiter for the shared eight-digit seven-segment display: DEFAULT, CPU and timed MSG sources.
// All driver-facing outputs are registered and computed from the next state.
module seg_display_arbiter #(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned HOLD_TICKS = 3,
  parameter int unsigned BLINK      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_we,
  input  logic [31:0] cpu_data,
  input  logic        cpu_base,
  input  logic        cpu_release,
  input  logic        msg_req,
  input  logic [31:0] msg_data,
  input  logic        msg_base,
  output logic        msg_ack,
  input  logic [31:0] dflt_data,
  input  logic        dflt_base,
  input  logic        blank,
  output logic [31:0] seg_data,
  output logic        seg_base,
  output logic        seg_en,
  output logic [1:0]  owner,
  output logic        busy
);

  localparam int unsigned H  = (HOLD_TICKS == 0) ? 1 : HOLD_TICKS;
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned HW = $clog2(H + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_INIT  = HW'(H);

  typedef enum logic [1:0] {
    ST_DEFAULT = 2'd0,
    ST_CPU     = 2'd1,
    ST_MSG     = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          cpu_owned_q, cpu_owned_d;
  logic [32:0]   cpu_val_q, cpu_val_d;
  logic [32:0]   msg_val_q, msg_val_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          blink_q, blink_d;
  logic          ack_q, ack_d;
  logic [31:0]   seg_data_q, seg_data_d;
  logic          seg_base_q, seg_base_d;
  logic          seg_en_q, seg_en_d;
  logic          tick;

  assign tick = (state_q == ST_MSG) && (presc_q == PRESC_LAST);

  always_comb begin
    state_d     = state_q;
    cpu_owned_d = cpu_owned_q;
    cpu_val_d   = cpu_val_q;
    msg_val_d   = msg_val_q;
    presc_d     = '0;
    hold_d      = hold_q;
    blink_d     = blink_q;
    ack_d       = 1'b0;
    seg_data_d  = dflt_data;
    seg_base_d  = dflt_base;

    // A write in the same cycle as a release keeps ownership.
    if (cpu_we) begin
      cpu_owned_d = 1'b1;
      cpu_val_d   = {cpu_base, cpu_data};
    end else if (cpu_release) begin
      cpu_owned_d = 1'b0;
    end

    case (state_q)
      ST_MSG: begin
        if (tick) begin
          hold_d  = hold_q - HW'(1);
          blink_d = ~blink_q;
          if (hold_q == HW'(1)) begin
            state_d = cpu_owned_d ? ST_CPU : ST_DEFAULT;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: begin
        if (msg_req) begin
          state_d   = ST_MSG;
          msg_val_d = {msg_base, msg_data};
          hold_d    = HOLD_INIT;
          blink_d   = 1'b0;
          ack_d     = 1'b1;
        end else begin
          state_d = cpu_owned_d ? ST_CPU : ST_DEFAULT;
        end
      end
    endcase

    case (state_d)
      ST_CPU: begin
        seg_data_d = cpu_val_d[31:0];
        seg_base_d = cpu_val_d[32];
      end
      ST_MSG: begin
        seg_data_d = msg_val_d[31:0];
        seg_base_d = msg_val_d[32];
      end
      default: ;
    endcase

    seg_en_d = !blank && !((state_d == ST_MSG) && (BLINK != 0) && blink_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_DEFAULT;
      cpu_owned_q <= 1'b0;
      cpu_val_q   <= '0;
      msg_val_q   <= '0;
      presc_q     <= '0;
      hold_q      <= '0;
      blink_q     <= 1'b0;
      ack_q       <= 1'b0;
      seg_data_q  <= '0;
      seg_base_q  <= 1'b0;
      seg_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpu_owned_q <= cpu_owned_d;
      cpu_val_q   <= cpu_val_d;
      msg_val_q   <= msg_val_d;
      presc_q     <= presc_d;
      hold_q      <= hold_d;
      blink_q     <= blink_d;
      ack_q       <= ack_d;
      seg_data_q  <= seg_data_d;
      seg_base_q  <= seg_base_d;
      seg_en_q    <= seg_en_d;
    end
  end

  assign msg_ack  = ack_q;
  assign seg_data = seg_data_q;
  assign seg_base = seg_base_q;
  assign seg_en   = seg_en_q;
  assign owner    = state_q;
  assign busy     = (state_q == ST_MSG);

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Owns the shared eight-digit seven-segment display and decides what it shows. Three sources compete for it: a default source (switches or debug value), CPU MMIO writes, and one-shot timed status messages sent with a request/acknowledge handshake. It is placed between those sources and the scan driver. It drives the driver's `data`, `base` and `en` inputs from registered outputs, and it makes timed messages blink.

## Interface
Parameters:
- `TICK_DIV`, default 50000: clock cycles per tick. Legal range is ≥ 2.
- `HOLD_TICKS`, default 3: number of ticks a message owns the display. A value of 0 is treated as 1.
- `BLINK`, default 1: 1 makes the display blink during a message; 0 holds it steady.

Ports:
- `clk` in 1: the single clock. Everything updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `cpu_we` in 1: CPU write strobe. Captures `cpu_data` and `cpu_base`.
- `cpu_data` in 32: value written by the CPU.
- `cpu_base` in 1: radix for the CPU value. 1 is decimal, 0 is hex.
- `cpu_release` in 1: CPU gives up ownership of the display.
- `msg_req` in 1: message request. The requester holds it high until it sees `msg_ack`.
- `msg_data` in 32: message value.
- `msg_base` in 1: message radix.
- `msg_ack` out 1: one-cycle pulse when a message is accepted.
- `dflt_data` in 32: default source value, passed through live.
- `dflt_base` in 1: default source radix.
- `blank` in 1: forces the display off. It has no effect on state.
- `seg_data` out 32: data to the display driver.
- `seg_base` out 1: radix to the display driver.
- `seg_en` out 1: display enable to the driver.
- `owner` out 2: current owner. 0 = DEFAULT, 1 = CPU, 2 = MSG.
- `busy` out 1: high while in MSG.

## Operation
- State machine: DEFAULT, CPU, MSG. Priority from highest to lowest: MSG, CPU, DEFAULT.
- Internal registers:
  - `cpu_val`, 33 bits: holds `cpu_data` and `cpu_base`.
  - `cpu_owned` flag.
  - `msg_val`, 33 bits.
  - Tick prescaler.
  - Hold counter.
  - `blink_ph`.
- `cpu_we`:
  - Always loads `cpu_val` and sets `cpu_owned`, in every state, including MSG.
  - In MSG the display does not change; the new value takes effect after the message ends.
- `cpu_release`:
  - Clears `cpu_owned`.
  - If it arrives together with `cpu_we`, the write wins: the value is loaded and `cpu_owned` stays 1.
- Transitions:
  - DEFAULT → CPU when `cpu_owned` is set, or `cpu_we` is high this cycle.
  - CPU → DEFAULT when `cpu_owned` clears.
  - Any state other than MSG → MSG when `msg_req` is high. This overrides the CPU transitions in the same cycle.
  - MSG → CPU on the final tick if `cpu_owned` is set at that point, otherwise MSG → DEFAULT.
- `msg_req` in MSG:
  - It is ignored: no ack is given and `msg_val` is not overwritten.
  - A request still held high at MSG exit is accepted on the next cycle. Two messages therefore run back-to-back with a single non-MSG cycle between them.
- On entry to MSG:
  - Load `msg_val`.
  - Clear the prescaler.
  - Load the hold counter with max(`HOLD_TICKS`, 1).
  - Clear `blink_ph`.
- Tick generation:
  - The prescaler counts from 0 to `TICK_DIV`-1 and runs only in MSG.
  - A tick fires on the cycle the prescaler equals `TICK_DIV`-1.
  - Each tick decrements the hold counter and toggles `blink_ph`.
  - The tick that brings the counter to 0 is the final tick.
- Output mux, registered and computed from the next state:
  - DEFAULT: `dflt_data` / `dflt_base`.
  - CPU: `cpu_val`. On the edge of a `cpu_we`, the new value is used.
  - MSG: `msg_val`.
- `seg_en` = !`blank` && !(next state is MSG && `BLINK` && next `blink_ph`). It is registered.
- `owner` and `busy` reflect the state after the edge.

## Timing
- Reset values, all driven at the rising edge with `rst` = 1:
  - State DEFAULT, `cpu_owned` 0, `cpu_val` 0, `msg_val` 0, counters 0, `blink_ph` 0.
  - `seg_data` 0, `seg_base` 0, `seg_en` 0, `msg_ack` 0, `owner` 0, `busy` 0.
- Reset in the middle of a message:
  - The message is aborted and no ack is given.
  - `msg_req` is ignored while `rst` is high.
- Pass-through latency is 1 cycle:
  - An input change before edge k appears at the outputs after edge k.
  - This applies to `dflt_data`, `blank`, and a `cpu_we` in CPU/DEFAULT state.
- Message acceptance: `msg_req` high at edge k (not in MSG) gives, after edge k:
  - `msg_ack` = 1 for exactly 1 cycle.
  - `owner` = 2, `busy` = 1, `seg_data` = `msg_data`, `seg_en` = !`blank`.
- MSG duration:
  - Exactly H·`TICK_DIV` cycles, where H = max(`HOLD_TICKS`, 1).
  - The exit edge is k + H·`TICK_DIV`. Ticks occur at edges k + j·`TICK_DIV` for j = 1..H.
- Blink: with `BLINK` = 1, `seg_en` is 1 for the first `TICK_DIV` cycles, then alternates every `TICK_DIV` cycles.
- Width rules: counters are sized by clog2 of the parameters, and no counter wraps. The prescaler is held at 0 outside MSG.

## Test plan
- **Reset and default:** `rst` for 2 cycles, then `dflt_data` = 0x1234, `dflt_base` = 0. Required: outputs 0 and `seg_en` = 0 during reset; one cycle after reset, `seg_data` = 0x1234, `seg_en` = 1, `owner` = 0.
- **CPU ownership:** `cpu_we` with 0xDEADBEEF, `cpu_base` = 0. Required: next cycle `seg_data` = 0xDEADBEEF and `owner` = 1. Then `cpu_we` and `cpu_release` together with 0x5: `owner` stays 1 and `seg_data` = 5. Then `cpu_release` alone: `owner` = 0 and `seg_data` = `dflt_data`.
- **Message timing** (`TICK_DIV` = 4, `HOLD_TICKS` = 3, `BLINK` = 1): `msg_req` with 99, base 1. Required: exactly one `msg_ack`; `busy` high for exactly 12 cycles; `seg_en` pattern 1111 0000 1111; then back to DEFAULT.
- **CPU write during MSG:** during the message, `cpu_we` with 0x77. Required: `seg_data` remains the message value; on exit, `owner` = 1 and `seg_data` = 0x77.
- **Back-to-back:** `msg_req` held high across two messages with the same settings. Required: second ack exactly 1 cycle after the first message exits; `msg_val` unchanged during the first message.
- **Abort and blank:** `rst` asserted in the middle of a message, which must return everything to reset values with no ack. `blank` = 1 in CPU state, which must give `seg_en` = 0 while `owner` stays 1. `HOLD_TICKS` = 0 must behave like 1.
